seq_det_arbiter: RTL

//  Time-shares one serial sequence detector (Mealy, 1-bit in, 1-bit match out)

---
 rtl/seq_det_arbiter_if.sv | 28 ++
 rtl/seq_det_arbiter.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/seq_det_arbiter_if.sv
// Bundle between the serial requesters, the arbiter and the shared sequence detector.
// The arbiter sits on the slave side; requesters and detector are the master side.
interface seq_det_arbiter_if #(
    parameter int NCH   = 4,
    parameter int CNT_W = 8
);
    logic [NCH-1:0]       req;
    logic [NCH-1:0]       bit_in;
    logic                 cnt_clr;
    logic [NCH-1:0]       grant;
    logic                 busy;
    logic                 det_clr;
    logic                 det_en;
    logic                 det_in;
    logic                 det_match;
    logic [NCH-1:0]       match_pulse;
    logic [NCH*CNT_W-1:0] match_cnt;

    modport master (
        output req, bit_in, cnt_clr, det_match,
        input  grant, busy, det_clr, det_en, det_in, match_pulse, match_cnt
    );

    modport slave (
        input  req, bit_in, cnt_clr, det_match,
        output grant, busy, det_clr, det_en, det_in, match_pulse, match_cnt
    );
endinterface

// File: rtl/seq_det_arbiter.sv
// Round-robin time-sharing of one Mealy sequence detector between NCH serial channels,
// one frame of FRAME_LEN bits per grant, with saturating per-channel match counters.
module seq_det_arbiter #(
    parameter int NCH       = 4,
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    seq_det_arbiter_if.slave    bus
);

    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int BC_W  = $clog2(FRAME_LEN + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CLEAR   = 2'd1,
        RUN     = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t               state_reg;
    logic [NCH-1:0]       grant_reg;
    logic [IDX_W-1:0]     ptr_reg;
    logic [IDX_W-1:0]     gidx_reg;
    logic [BC_W-1:0]      bit_cnt_reg;
    logic                 busy_reg;
    logic                 det_clr_reg;
    logic [NCH-1:0]       match_pulse_reg;

    logic                 found_next;
    logic [IDX_W-1:0]     pick_next;
    logic                 req_g;
    logic                 det_en;
    logic                 hit;

    // Channel index k+1 places after the round-robin pointer.
    function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] p, input int k);
        int s;
        s = (int'(p) + k + 1) % NCH;
        return IDX_W'(s);
    endfunction

    always_comb begin
        found_next = 1'b0;
        pick_next  = '0;
        for (int k = 0; k < NCH; k++) begin
            if (!found_next && bus.req[rr_idx(ptr_reg, k)]) begin
                found_next = 1'b1;
                pick_next  = rr_idx(ptr_reg, k);
            end
        end
    end

    // grant_reg is one-hot or zero, so AND-OR acts as the channel mux.
    assign req_g  = |(grant_reg & bus.req);
    assign det_en = (state_reg == RUN) && req_g;
    assign hit    = det_en && bus.det_match;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            grant_reg   <= '0;
            ptr_reg     <= IDX_W'(NCH - 1);
            gidx_reg    <= '0;
            bit_cnt_reg <= '0;
            busy_reg    <= 1'b0;
            det_clr_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (found_next) begin
                        grant_reg   <= NCH'(1) << pick_next;
                        gidx_reg    <= pick_next;
                        busy_reg    <= 1'b1;
                        det_clr_reg <= 1'b1;
                        state_reg   <= CLEAR;
                    end
                end
                CLEAR: begin
                    det_clr_reg <= 1'b0;
                    bit_cnt_reg <= '0;
                    state_reg   <= RUN;
                end
                RUN: begin
                    if (!req_g) begin
                        busy_reg  <= 1'b0;
                        state_reg <= RELEASE;
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg + BC_W'(1);
                        if (bit_cnt_reg == BC_W'(FRAME_LEN - 1)) begin
                            busy_reg  <= 1'b0;
                            state_reg <= RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    grant_reg <= '0;
                    ptr_reg   <= gidx_reg;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_pulse_reg <= '0;
        end else begin
            match_pulse_reg <= hit ? grant_reg : '0;
        end
    end

    // Clear beats a coincident match; counters stick at all-ones.
    for (genvar gi = 0; gi < NCH; gi++) begin : g_cnt
        logic [CNT_W-1:0] cnt_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_reg <= '0;
            end else if (bus.cnt_clr) begin
                cnt_reg <= '0;
            end else if (hit && grant_reg[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end

        assign bus.match_cnt[gi*CNT_W +: CNT_W] = cnt_reg;
    end

    assign bus.grant       = grant_reg;
    assign bus.busy        = busy_reg;
    assign bus.det_clr     = det_clr_reg;
    assign bus.det_en      = det_en;
    assign bus.det_in      = |(grant_reg & bus.bit_in);
    assign bus.match_pulse = match_pulse_reg;

endmodule
